// File: rtl/uart_rx_if.sv
// Host-side bus of the UART receiver: received word, status flags and the acknowledge.
interface uart_rx_if #(
    parameter int unsigned WORD_LENGTH = 8
);
    logic [WORD_LENGTH-1:0] Data;
    logic                   Rx_Flag;
    logic                   Frame_Error;
    logic                   Overrun;
    logic                   Clr_Flag;

    modport master (
        output Data,
        output Rx_Flag,
        output Frame_Error,
        output Overrun,
        input  Clr_Flag
    );

    modport slave (
        input  Data,
        input  Rx_Flag,
        input  Frame_Error,
        input  Overrun,
        output Clr_Flag
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x (configurable) oversampling, sticky ready/overrun
// flags and a per-frame framing-error flag, all presented on registered outputs.
module uart_rx #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      Tick,
    input  logic      Rx,
    uart_rx_if.master host
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(WORD_LENGTH + 1);
    localparam int unsigned HALF  = OVERSAMPLE / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic                   flag_q, flag_d;
    logic                   fe_q, fe_d;
    logic                   ovr_q, ovr_d;
    logic                   armed_q, armed_d;
    logic                   at_half;
    logic                   at_full;

    assign rx_s    = sync_q[1];
    assign at_half = Tick && (cnt_q == CNT_W'(HALF - 1));
    assign at_full = Tick && (cnt_q == CNT_W'(OVERSAMPLE - 1));

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], Rx};
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = Tick ? cnt_q + CNT_W'(1) : cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        flag_d  = flag_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        armed_d = armed_q | rx_s;

        // Acknowledge is applied first so a completing frame overrides it.
        if (host.Clr_Flag) begin
            flag_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // armed_q blocks re-triggering on a held-low (break) line.
                if (!rx_s && armed_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_half) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[WORD_LENGTH-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORD_LENGTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (at_full) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    flag_d  = 1'b1;
                    fe_d    = ~rx_s;
                    if (flag_q && !host.Clr_Flag) begin
                        ovr_d = 1'b1;
                    end
                    if (!rx_s) begin
                        armed_d = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign host.Data        = data_q;
    assign host.Rx_Flag     = flag_q;
    assign host.Frame_Error = fe_q;
    assign host.Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: timing, framing error, overrun,
// glitch rejection, break, slow tick, acknowledge collision and mid-frame reset.
module tb_uart_rx;

    logic Clk;
    logic Reset;
    logic Tick;
    logic Rx;
    logic Clr_Flag;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int rise;

    uart_rx_if #(.WORD_LENGTH(8)) ifc ();
    assign ifc.Clr_Flag = Clr_Flag;

    uart_rx #(
        .WORD_LENGTH(8),
        .OVERSAMPLE (16)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Tick (Tick),
        .Rx   (Rx),
        .host (ifc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_clr();
        Clr_Flag = 1'b1;
        cycles(1);
        Clr_Flag = 1'b0;
    endtask

    // Drives one frame starting #1 after an edge; cycle c of the frame is sampled at edge c+1.
    // rise_at reports the edge index (from frame start) where Rx_Flag went 0->1, or -1.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int period,
                              input int tdiv, input int clr_at, input int abort_at,
                              input logic idle_lvl, output int rise_at);
        logic prev;
        int   k;
        rise_at = -1;
        for (int c = 0; c < 10 * period; c++) begin
            if (c == abort_at) return;
            k = c / period;
            if (k == 0)      Rx = 1'b0;
            else if (k == 9) Rx = stop;
            else             Rx = b[k-1];
            Tick     = ((c % tdiv) == 0);
            Clr_Flag = (c == clr_at);
            prev     = ifc.Rx_Flag;
            cycles(1);
            if (!prev && ifc.Rx_Flag && rise_at < 0) rise_at = c + 1;
        end
        Rx       = idle_lvl;
        Clr_Flag = 1'b0;
        Tick     = 1'b1;
        cycles(8);
    endtask

    initial begin
        Reset    = 1'b0;
        Tick     = 1'b1;
        Rx       = 1'b1;
        Clr_Flag = 1'b0;
        cycles(3);
        Reset = 1'b1;
        cycles(2);

        check("reset_data", 32'(ifc.Data), 32'h00);
        check("reset_flag", 32'(ifc.Rx_Flag), 32'd0);
        check("reset_fe", 32'(ifc.Frame_Error), 32'd0);
        check("reset_ovr", 32'(ifc.Overrun), 32'd0);

        // 1: basic frame and flag latency (2 sync + 1 idle + 152)
        send_frame(8'hA5, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        check("t1_rise", 32'(rise), 32'd155);
        check("t1_data", 32'(ifc.Data), 32'hA5);
        check("t1_flag", 32'(ifc.Rx_Flag), 32'd1);
        check("t1_fe", 32'(ifc.Frame_Error), 32'd0);
        check("t1_ovr", 32'(ifc.Overrun), 32'd0);

        // 2: framing error, acknowledge leaves it, good frame rewrites it
        pulse_clr();
        send_frame(8'h3C, 1'b0, 16, 1, -1, -1, 1'b1, rise);
        check("t2_data", 32'(ifc.Data), 32'h3C);
        check("t2_flag", 32'(ifc.Rx_Flag), 32'd1);
        check("t2_fe", 32'(ifc.Frame_Error), 32'd1);
        pulse_clr();
        check("t2_fe_after_clr", 32'(ifc.Frame_Error), 32'd1);
        check("t2_flag_after_clr", 32'(ifc.Rx_Flag), 32'd0);
        send_frame(8'h81, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        check("t2_data81", 32'(ifc.Data), 32'h81);
        check("t2_fe_good", 32'(ifc.Frame_Error), 32'd0);

        // 3: overrun
        pulse_clr();
        send_frame(8'h11, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        send_frame(8'h22, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        check("t3_data", 32'(ifc.Data), 32'h22);
        check("t3_flag", 32'(ifc.Rx_Flag), 32'd1);
        check("t3_ovr", 32'(ifc.Overrun), 32'd1);
        pulse_clr();
        check("t3_flag_clr", 32'(ifc.Rx_Flag), 32'd0);
        check("t3_ovr_clr", 32'(ifc.Overrun), 32'd0);

        // 4: short low glitch is rejected
        Tick = 1'b1;
        Rx   = 1'b0;
        cycles(4);
        Rx = 1'b1;
        cycles(20);
        check("t4_glitch_data", 32'(ifc.Data), 32'h22);
        check("t4_glitch_flag", 32'(ifc.Rx_Flag), 32'd0);
        send_frame(8'h5A, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        check("t4_data", 32'(ifc.Data), 32'h5A);
        check("t4_flag", 32'(ifc.Rx_Flag), 32'd1);

        // break: one zero frame, then no retrigger while the line stays low
        pulse_clr();
        send_frame(8'h00, 1'b0, 16, 1, -1, -1, 1'b0, rise);
        check("brk_data", 32'(ifc.Data), 32'h00);
        check("brk_fe", 32'(ifc.Frame_Error), 32'd1);
        check("brk_flag", 32'(ifc.Rx_Flag), 32'd1);
        pulse_clr();
        cycles(200);
        check("brk_no_retrigger", 32'(ifc.Rx_Flag), 32'd0);
        Rx = 1'b1;
        cycles(4);

        // 5: tick every 4th cycle; completion edge is 609, acknowledge driven in cycle 608
        send_frame(8'hFF, 1'b1, 64, 4, 608, -1, 1'b1, rise);
        check("t5_rise", 32'(rise), 32'd609);
        check("t5_data", 32'(ifc.Data), 32'hFF);
        check("t5_flag_setwins", 32'(ifc.Rx_Flag), 32'd1);
        check("t5_fe", 32'(ifc.Frame_Error), 32'd0);
        send_frame(8'hFF, 1'b1, 64, 4, 608, -1, 1'b1, rise);
        check("t5b_flag", 32'(ifc.Rx_Flag), 32'd1);
        check("t5b_no_ovr", 32'(ifc.Overrun), 32'd0);

        // 6: asynchronous reset in the middle of data bit 4
        send_frame(8'h96, 1'b1, 16, 1, -1, 88, 1'b1, rise);
        Reset = 1'b0;
        #1;
        check("t6_rst_data", 32'(ifc.Data), 32'h00);
        check("t6_rst_flag", 32'(ifc.Rx_Flag), 32'd0);
        check("t6_rst_fe", 32'(ifc.Frame_Error), 32'd0);
        check("t6_rst_ovr", 32'(ifc.Overrun), 32'd0);
        Rx = 1'b1;
        cycles(2);
        Reset = 1'b1;
        cycles(4);
        send_frame(8'h69, 1'b1, 16, 1, -1, -1, 1'b1, rise);
        check("t6_data", 32'(ifc.Data), 32'h69);
        check("t6_flag", 32'(ifc.Rx_Flag), 32'd1);
        check("t6_ovr", 32'(ifc.Overrun), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
